ariane_timer_mc: RTL and testbench
==================================

Name: ariane_timer_mc

Overview:
Next-generation machine timer for the Ariane SoC. It holds one free-running mtime counter of parametrised width, with a programmable prescaler and a selectable tick source (synchronised RTC edge or core clock). It also holds NR_HARTS independent mtimecmp registers, each driving one timer interrupt. Software reaches the registers through a simple request/response register port; the block sits behind the SoC's bus-to-register adapter and feeds time_o to all cores.

Parameters:
NR_HARTS, 1, number of harts; one mtimecmp register and one irq line per hart (1..16)
CNT_WIDTH, 64, mtime/mtimecmp width in bits (32..64)
PRESC_WIDTH, 8, prescaler field width
ADDR_WIDTH, 12, register-port byte address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_i  in  1  register access request; always granted
we_i  in  1  1=write, 0=read
addr_i  in  ADDR_WIDTH  byte address; bits [2:0] ignored
wdata_i  in  64  write data
rvalid_o  out  1  response strobe, exactly 1 cycle after each req_i
rdata_o  out  64  read data, valid with rvalid_o; 0 for writes
err_o  out  1  unmapped address, valid with rvalid_o
halted_i  in  1  cores halted; freezes the counter
rtc_i  in  1  asynchronous real-time clock input
time_o  out  CNT_WIDTH  mtime_q
irq_o  out  NR_HARTS  per-hart timer interrupt (level)

Behaviour:
- Reset values: all outputs 0; mtime 0; every mtimecmp 0; CTRL 0 (disabled, src=RTC, presc=0); synchroniser and prescaler counter 0.
- Register map (byte offsets):
  - 0x000 CTRL: bit0 EN; bit1 SRC (0=RTC rising edge, 1=every clk_i); bits[8+PRESC_WIDTH-1:8] PRESC.
  - 0x008 MTIME.
  - 0x100+8*h TIMECMP[h], h<NR_HARTS.
  - All other offsets unmapped: reads return 0, err_o=1, writes have no effect.
- Accesses: a read returns the register value before any same-cycle update. A write takes effect on the next clock edge. Values narrower than 64 bits are zero-extended on read and truncated on write.
- RTC path: rtc_i passes through a 2-flop synchroniser plus an edge register. A rising edge yields a 1-cycle raw tick 3 cycles after rtc_i rises.
- Tick:
  - raw = SRC ? 1 : rtc_edge.
  - When EN && raw && !halted_i: if presc_cnt==PRESC then tick=1 and presc_cnt=0; else presc_cnt++.
  - Consequence: mtime increments once per PRESC+1 raw ticks.
  - halted_i or !EN freezes presc_cnt; raw ticks seen during that time are lost.
  - Any CTRL write clears presc_cnt.
- mtime: a tick increments it, wrapping modulo 2^CNT_WIDTH (all-ones -> 0, no flag). A bus write to MTIME in the same cycle wins over the increment.
- irq_o[h] is registered: irq_o[h] <= (cmp_n[h]!=0) && (mtime_n >= cmp_n[h]), an unsigned compare on next-state values. It therefore rises in the same cycle mtime_q reaches cmp_q.
- Writing TIMECMP[h] above mtime deasserts irq_o[h] on the next edge. Writing cmp=0 disables hart h.
- Reset mid-operation: every register returns to its reset value on the first clk_i edge with rst_i=1. A response to a request issued in the reset cycle is suppressed.

Optional Feature:
Macro ARIANE_TIMER_PERIODIC_EN.
- Defined:
  - Adds PERIOD[h] registers at 0x200+8*h, reset 0.
  - When PERIOD[h]!=0 and the compare matches, cmp[h] <= cmp[h]+PERIOD[h] (mod 2^CNT_WIDTH) in the match cycle. A sticky pend[h] is set at the same time.
  - In this mode irq_o[h]=pend[h]. A write to TIMECMP[h] or PERIOD[h] clears pend[h]; the write wins over a same-cycle set.
  - Harts with PERIOD[h]==0 behave exactly as without the macro.
- Undefined: offsets 0x200.. are unmapped (err_o=1); no extra flops.

Decomposition:
- Package ariane_timer_pkg holds:
  - register offset constants: CTRL_OFF, MTIME_OFF, CMP_BASE, PERIOD_BASE;
  - ctrl_t packed struct {presc, src, en};
  - a function that decodes an address to {kind, hart index}.
- Sub-module timer_tick_gen: RTC synchroniser, edge detect, source mux and prescaler. Inputs: clk_i, rst_i, rtc_i, en, src, presc, clr, halted_i. Output: tick_o.

Test Plan:
- Reset, then read CTRL/MTIME/TIMECMP[0] -> rdata 0, err_o 0, irq_o 0, time_o 0; read offset 0x0F8 -> err_o=1, rdata 0.
- CTRL=0x0303 (EN, SRC=clk, PRESC=3), run 40 cycles -> MTIME=10 (+/-1 for the write cycle); assert halted_i 8 cycles -> MTIME unchanged.
- SRC=RTC, PRESC=0, toggle rtc_i with 5 rising edges -> MTIME=5, each increment 3-4 cycles after its edge.
- NR_HARTS=2: TIMECMP[1]=20, SRC=clk, PRESC=0 -> irq_o=2'b10 in the cycle time_o==20; write TIMECMP[1]=100 -> irq_o=0 next cycle; irq_o[0] stays 0 (cmp=0).
- CNT_WIDTH=32: MTIME=0xFFFF_FFFE, run 2 ticks -> time_o=0; same-cycle MTIME write 0x55 plus tick -> 0x55.
- With ARIANE_TIMER_PERIODIC_EN: TIMECMP[0]=10, PERIOD[0]=10 -> cmp becomes 20 at time 10, irq_o[0]=1 until a TIMECMP[0] write, then re-fires at time 20.

Source files
------------

// File: rtl/ariane_timer_pkg.sv
// Shared definitions for the Ariane machine timer: register offsets, control
// layout and the register-port address decoder.
package ariane_timer_pkg;

  localparam logic [15:0] CTRL_OFF    = 16'h000;
  localparam logic [15:0] MTIME_OFF   = 16'h008;
  localparam logic [15:0] CMP_BASE    = 16'h100;
  localparam logic [15:0] PERIOD_BASE = 16'h200;

  localparam int unsigned CTRL_WORD   = 32'(CTRL_OFF) >> 3;
  localparam int unsigned MTIME_WORD  = 32'(MTIME_OFF) >> 3;
  localparam int unsigned CMP_WORD    = 32'(CMP_BASE) >> 3;
  localparam int unsigned PERIOD_WORD = 32'(PERIOD_BASE) >> 3;

  // Widest supported prescaler; narrower builds keep the upper bits at zero.
  localparam int unsigned CTRL_PRESC_W = 16;

  typedef struct packed {
    logic [CTRL_PRESC_W-1:0] presc;
    logic                    src;
    logic                    en;
  } ctrl_t;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_MTIME,
    REG_CMP,
    REG_PERIOD,
    REG_NONE
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [3:0] hart;
  } reg_sel_t;

  // Decodes a 64-bit word index (byte address >> 3) into register kind and hart.
  function automatic reg_sel_t decode_addr(input logic [12:0] word_addr,
                                           input int unsigned nr_harts,
                                           input logic        periodic);
    reg_sel_t    sel;
    int unsigned word;
    word     = {19'd0, word_addr};
    sel.kind = REG_NONE;
    sel.hart = '0;
    if (word == CTRL_WORD) begin
      sel.kind = REG_CTRL;
    end else if (word == MTIME_WORD) begin
      sel.kind = REG_MTIME;
    end else if (word >= CMP_WORD && word < CMP_WORD + nr_harts) begin
      sel.kind = REG_CMP;
      sel.hart = 4'(word - CMP_WORD);
    end else if (periodic && word >= PERIOD_WORD && word < PERIOD_WORD + nr_harts) begin
      sel.kind = REG_PERIOD;
      sel.hart = 4'(word - PERIOD_WORD);
    end
    return sel;
  endfunction

endpackage

// File: rtl/ariane_timer_mc_tick_gen.sv
// Tick generator: RTC synchroniser and edge detect, tick source mux and
// prescaler. tick_o is a single-cycle strobe that advances mtime.
module timer_tick_gen
  import ariane_timer_pkg::*;
#(
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rtc_i,
  input  logic                   en,
  input  logic                   src,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic                   clr,
  input  logic                   halted_i,
  output logic                   tick_o
);

  // [0],[1] form the synchroniser for the asynchronous RTC; [2] holds the
  // previous synchronised level for edge detection.
  logic [2:0]             rtc_q;
  logic [PRESC_WIDTH-1:0] presc_cnt_q;
  logic                   rtc_edge;
  logic                   step;
  logic                   hit;

  // NOTE: reset is synchronous, so it sits inside the clocked branch rather
  // than in the sensitivity list; all state uses non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rtc_q <= '0;
    end else begin
      rtc_q <= {rtc_q[1:0], rtc_i};
    end
  end

  assign rtc_edge = rtc_q[1] & ~rtc_q[2];
  assign step     = en & (src | rtc_edge) & ~halted_i;
  assign hit      = (presc_cnt_q == presc);
  assign tick_o   = step & hit;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      presc_cnt_q <= '0;
    end else if (step) begin
      presc_cnt_q <= hit ? '0 : presc_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ariane_timer_mc.sv
// Ariane machine timer: prescaled mtime counter, per-hart mtimecmp and irq,
// single-cycle register port. Optional periodic mode: ARIANE_TIMER_PERIODIC_EN.
module ariane_timer_mc
  import ariane_timer_pkg::*;
#(
  parameter int unsigned NR_HARTS    = 1,
  parameter int unsigned CNT_WIDTH   = 64,
  parameter int unsigned PRESC_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [63:0]           rdata_o,
  output logic                  err_o,
  input  logic                  halted_i,
  input  logic                  rtc_i,
  output logic [CNT_WIDTH-1:0]  time_o,
  output logic [NR_HARTS-1:0]   irq_o
);

`ifdef ARIANE_TIMER_PERIODIC_EN
  localparam logic PERIODIC = 1'b1;
`else
  localparam logic PERIODIC = 1'b0;
`endif

  ctrl_t                ctrl_q;
  logic [CNT_WIDTH-1:0] mtime_q, mtime_n;
  logic [CNT_WIDTH-1:0] cmp_q [NR_HARTS];
  logic [CNT_WIDTH-1:0] cmp_n [NR_HARTS];
  logic [NR_HARTS-1:0]  cmp_wr;
  logic [NR_HARTS-1:0]  irq_q, irq_n;
  logic [63:0]          rdata_n;
  logic                 rvalid_q, err_q;
  logic [63:0]          rdata_q;
  logic                 tick;
  logic                 wr, rd, ctrl_wr, mtime_wr;
  logic                 unused_addr;
  reg_sel_t             sel;

  assign unused_addr = ^addr_i[2:0];
  assign sel      = decode_addr(13'(addr_i[ADDR_WIDTH-1:3]), NR_HARTS, PERIODIC);
  assign wr       = req_i & we_i;
  assign rd       = req_i & ~we_i;
  assign ctrl_wr  = wr && (sel.kind == REG_CTRL);
  assign mtime_wr = wr && (sel.kind == REG_MTIME);

  always_comb begin
    for (int h = 0; h < NR_HARTS; h++) begin
      cmp_wr[h] = wr && (sel.kind == REG_CMP) && (sel.hart == 4'(h));
    end
  end

  timer_tick_gen #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_tick_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rtc_i    (rtc_i),
    .en       (ctrl_q.en),
    .src      (ctrl_q.src),
    .presc    (ctrl_q.presc[PRESC_WIDTH-1:0]),
    .clr      (ctrl_wr),
    .halted_i (halted_i),
    .tick_o   (tick)
  );

  // A bus write to MTIME wins over a same-cycle increment.
  assign mtime_n = mtime_wr ? wdata_i[CNT_WIDTH-1:0]
                 : tick     ? mtime_q + 1'b1
                 :            mtime_q;

`ifdef ARIANE_TIMER_PERIODIC_EN
  logic [CNT_WIDTH-1:0] period_q [NR_HARTS];
  logic [CNT_WIDTH-1:0] period_n [NR_HARTS];
  logic [NR_HARTS-1:0]  period_wr;
  logic [NR_HARTS-1:0]  pend_q, pend_n;
  logic [NR_HARTS-1:0]  match;

  // NOTE: every combinationally assigned variable gets a default at the top
  // of its block so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int h = 0; h < NR_HARTS; h++) begin
      period_wr[h] = wr && (sel.kind == REG_PERIOD) && (sel.hart == 4'(h));
      period_n[h]  = period_wr[h] ? wdata_i[CNT_WIDTH-1:0] : period_q[h];
      match[h]     = (cmp_q[h] != '0) && (mtime_n >= cmp_q[h]);
      cmp_n[h]     = cmp_q[h];
      pend_n[h]    = pend_q[h];
      if (cmp_wr[h]) begin
        cmp_n[h] = wdata_i[CNT_WIDTH-1:0];
      end else if (period_q[h] != '0 && match[h]) begin
        cmp_n[h] = cmp_q[h] + period_q[h];
      end
      if (cmp_wr[h] || period_wr[h]) begin
        pend_n[h] = 1'b0;
      end else if (period_q[h] != '0 && match[h]) begin
        pend_n[h] = 1'b1;
      end
      irq_n[h] = (period_n[h] != '0) ? pend_n[h]
                                     : (cmp_n[h] != '0) && (mtime_n >= cmp_n[h]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      for (int h = 0; h < NR_HARTS; h++) period_q[h] <= '0;
    end else begin
      pend_q <= pend_n;
      for (int h = 0; h < NR_HARTS; h++) period_q[h] <= period_n[h];
    end
  end
`else
  always_comb begin
    for (int h = 0; h < NR_HARTS; h++) begin
      cmp_n[h] = cmp_wr[h] ? wdata_i[CNT_WIDTH-1:0] : cmp_q[h];
      irq_n[h] = (cmp_n[h] != '0) && (mtime_n >= cmp_n[h]);
    end
  end
`endif

  // Read data reflects register state before any same-cycle update.
  always_comb begin
    rdata_n = '0;
    if (rd) begin
      case (sel.kind)
        REG_CTRL: begin
          rdata_n[0]                 = ctrl_q.en;
          rdata_n[1]                 = ctrl_q.src;
          rdata_n[8 +: CTRL_PRESC_W] = ctrl_q.presc;
        end
        REG_MTIME: rdata_n[CNT_WIDTH-1:0] = mtime_q;
        REG_CMP: begin
          for (int h = 0; h < NR_HARTS; h++) begin
            if (sel.hart == 4'(h)) rdata_n[CNT_WIDTH-1:0] = cmp_q[h];
          end
        end
`ifdef ARIANE_TIMER_PERIODIC_EN
        REG_PERIOD: begin
          for (int h = 0; h < NR_HARTS; h++) begin
            if (sel.hart == 4'(h)) rdata_n[CNT_WIDTH-1:0] = period_q[h];
          end
        end
`endif
        default: rdata_n = '0;
      endcase
    end
  end

  // NOTE: the compare bank is a handful of flops, not a RAM, so every entry is
  // reset explicitly to give a defined irq state out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      mtime_q  <= '0;
      irq_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      for (int h = 0; h < NR_HARTS; h++) cmp_q[h] <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q.en    <= wdata_i[0];
        ctrl_q.src   <= wdata_i[1];
        ctrl_q.presc <= CTRL_PRESC_W'(wdata_i[8 +: PRESC_WIDTH]);
      end
      mtime_q  <= mtime_n;
      irq_q    <= irq_n;
      rvalid_q <= req_i;
      rdata_q  <= rdata_n;
      err_q    <= req_i && (sel.kind == REG_NONE);
      for (int h = 0; h < NR_HARTS; h++) cmp_q[h] <= cmp_n[h];
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign time_o   = mtime_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_ariane_timer_mc.sv
// Self-checking bench for ariane_timer_mc (2 harts, 32-bit counter): register
// responses are scoreboarded; counter and irq behaviour are checked directly.
module tb_ariane_timer_mc;

  localparam int unsigned NR_HARTS  = 2;
  localparam int unsigned CNT_WIDTH = 32;
  localparam logic [11:0] A_CTRL  = 12'h000;
  localparam logic [11:0] A_MTIME = 12'h008;
  localparam logic [11:0] A_CMP0  = 12'h100;
  localparam logic [11:0] A_CMP1  = 12'h108;
  localparam logic [11:0] A_PER0  = 12'h200;
`ifdef ARIANE_TIMER_PERIODIC_EN
  localparam logic PER_ERR = 1'b0;
`else
  localparam logic PER_ERR = 1'b1;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 req_i = 1'b0;
  logic                 we_i = 1'b0;
  logic [11:0]          addr_i = '0;
  logic [63:0]          wdata_i = '0;
  logic                 rvalid_o;
  logic [63:0]          rdata_o;
  logic                 err_o;
  logic                 halted_i = 1'b0;
  logic                 rtc_i = 1'b0;
  logic [CNT_WIDTH-1:0] time_o;
  logic [NR_HARTS-1:0]  irq_o;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    longint      t;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   n_req = 0;

  ariane_timer_mc #(
    .NR_HARTS    (NR_HARTS),
    .CNT_WIDTH   (CNT_WIDTH),
    .PRESC_WIDTH (8),
    .ADDR_WIDTH  (12)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .halted_i (halted_i),
    .rtc_i    (rtc_i),
    .time_o   (time_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responses are popped on the falling edge; request driven at posedge+1,
  // so a one-cycle response arrives 14 time units later.
  always @(negedge clk_i) begin
    if (rvalid_o) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", 64'(rvalid_o), 64'd0);
      end else begin
        cur = sb.pop_front();
        check($sformatf("rsp%0d_lat", cur.id), 64'($time - cur.t), 64'd14);
        check($sformatf("rsp%0d_rdata", cur.id), rdata_o, cur.rdata);
        check($sformatf("rsp%0d_err", cur.id), 64'(err_o), 64'(cur.err));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request was sampled.
  task automatic access(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err);
    exp_t e;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wd;
    e.rdata = we ? 64'd0 : exp_rd;
    e.err   = exp_err;
    e.t     = longint'($time);
    e.id    = n_req;
    n_req++;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [63:0] wd, input logic exp_err = 1'b0);
    access(1'b1, addr, wd, 64'd0, exp_err);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [63:0] exp, input logic exp_err = 1'b0);
    access(1'b0, addr, 64'd0, exp, exp_err);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_time(input logic [CNT_WIDTH-1:0] target, input int budget, input string tag);
    int n = 0;
    while (time_o !== target && n < budget) begin
      cycles(1);
      n++;
    end
    check(tag, 64'(time_o), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and reset values
    cycles(3);
    rst_i = 1'b0;
    check("rst_time", 64'(time_o), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    rd(A_CTRL, 64'd0);
    rd(A_MTIME, 64'd0);
    rd(A_CMP0, 64'd0);
    rd(12'h0F8, 64'd0, 1'b1);
    wr(A_PER0, 64'd0, PER_ERR);
    rd(A_PER0, 64'd0, PER_ERR);

    // Core-clock source, prescaler 3: one tick per 4 cycles
    wr(A_CTRL, 64'h0303);
    cycles(40);
    check("presc_mtime", 64'(time_o), 64'd10);
    halted_i = 1'b1;
    cycles(8);
    check("halt_mtime", 64'(time_o), 64'd10);
    rd(A_MTIME, 64'd10);
    rd(A_CTRL, 64'h0303);
    wr(A_CTRL, 64'h0);
    halted_i = 1'b0;

    // RTC source: increment lands on the third edge after rtc_i rises
    wr(A_MTIME, 64'd0);
    wr(A_CTRL, 64'h0001);
    for (int k = 1; k <= 5; k++) begin
      rtc_i = 1'b1;
      cycles(2);
      check($sformatf("rtc%0d_before", k), 64'(time_o), 64'(k - 1));
      cycles(1);
      check($sformatf("rtc%0d_after", k), 64'(time_o), 64'(k));
      cycles(1);
      rtc_i = 1'b0;
      cycles(4);
    end
    rd(A_MTIME, 64'd5);

    // Per-hart compare and interrupt
    wr(A_CTRL, 64'h0);
    wr(A_MTIME, 64'd0);
    wr(A_CMP1, 64'd20);
    rd(A_CMP1, 64'd20);
    check("irq_idle", 64'(irq_o), 64'd0);
    wr(A_CTRL, 64'h0003);
    wait_time(19, 40, "reach19");
    check("irq_at19", 64'(irq_o), 64'd0);
    cycles(1);
    check("time20", 64'(time_o), 64'd20);
    check("irq_at20", 64'(irq_o), 64'b10);
    cycles(2);
    check("irq_held", 64'(irq_o), 64'b10);
    wr(A_CMP1, 64'd100);
    check("irq_cleared", 64'(irq_o), 64'd0);

    // Counter wrap and write-over-increment
    wr(A_CTRL, 64'h0);
    wr(A_MTIME, 64'hFFFF_FFFE);
    rd(A_MTIME, 64'hFFFF_FFFE);
    wr(A_CTRL, 64'h0003);
    cycles(2);
    check("wrap_time", 64'(time_o), 64'd0);
    check("wrap_irq", 64'(irq_o), 64'd0);
    wr(A_MTIME, 64'h55);
    check("wr_wins", 64'(time_o), 64'h55);
    wr(A_CTRL, 64'h0);
    rd(A_MTIME, 64'h56);

`ifdef ARIANE_TIMER_PERIODIC_EN
    // Periodic reload with sticky pending
    wr(A_MTIME, 64'd0);
    wr(A_CMP0, 64'd10);
    wr(A_PER0, 64'd10);
    wr(A_CTRL, 64'h0003);
    wait_time(10, 40, "per_reach10");
    check("per_irq10", 64'(irq_o[0]), 64'd1);
    rd(A_CMP0, 64'd20);
    cycles(2);
    check("per_sticky", 64'(irq_o[0]), 64'd1);
    wr(A_CMP0, 64'd20);
    check("per_cleared", 64'(irq_o[0]), 64'd0);
    wait_time(20, 40, "per_reach20");
    check("per_irq20", 64'(irq_o[0]), 64'd1);
`endif

    // Reset mid-operation; request issued in the reset cycle gets no response
    wr(A_CTRL, 64'h0003);
    cycles(3);
    rst_i  = 1'b1;
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = A_MTIME;
    cycles(1);
    rst_i = 1'b0;
    req_i = 1'b0;
    check("rst2_time", 64'(time_o), 64'd0);
    check("rst2_irq", 64'(irq_o), 64'd0);
    check("rst2_rvalid", 64'(rvalid_o), 64'd0);
    rd(A_CTRL, 64'd0);
    rd(A_CMP1, 64'd0);
    rd(A_MTIME, 64'd0);

    cycles(3);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
